universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 100 ++++++++++
 tb/tb_universal_shift_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift up / shift down / parallel load, with
// a saturating shift counter and a frame-done pulse. Rotate feedback is built in with USR_ROTATE_EN.
module universal_shift_reg #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [DATA_W-1:0]            s_in,
  input  logic                         rot,
  input  logic [DEPTH*DATA_W-1:0]      p_in,
  output logic [DEPTH*DATA_W-1:0]      p_out,
  output logic [DATA_W-1:0]            s_out_up,
  output logic [DATA_W-1:0]            s_out_dn,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         done
);

  localparam int unsigned TOTAL_W = DEPTH * DATA_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [TOTAL_W-1:0] r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;

  logic [TOTAL_W-1:0] w_data_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_done_next;
  logic [DATA_W-1:0]  w_fill_up;
  logic [DATA_W-1:0]  w_fill_dn;

  // Serial feed for each direction: s_in, or the opposite end lane when rotating.
`ifdef USR_ROTATE_EN
  assign w_fill_up = rot ? r_data[TOTAL_W-1 -: DATA_W] : s_in;
  assign w_fill_dn = rot ? r_data[DATA_W-1:0]          : s_in;
`else
  logic w_unused_rot;
  assign w_unused_rot = rot;
  assign w_fill_up    = s_in;
  assign w_fill_dn    = s_in;
`endif

  always_comb begin
    w_data_next = r_data;
    w_cnt_next  = r_cnt;
    w_done_next = 1'b0;
    if (en) begin
      case (mode)
        MODE_UP: begin
          w_data_next = {r_data[TOTAL_W-DATA_W-1:0], w_fill_up};
          if (r_cnt != CNT_MAX) w_cnt_next = r_cnt + CNT_W'(1);
          w_done_next = (r_cnt == CNT_LAST);
        end
        MODE_DN: begin
          w_data_next = {w_fill_dn, r_data[TOTAL_W-1:DATA_W]};
          if (r_cnt != CNT_MAX) w_cnt_next = r_cnt + CNT_W'(1);
          w_done_next = (r_cnt == CNT_LAST);
        end
        MODE_LOAD: begin
          w_data_next = p_in;
          w_cnt_next  = '0;
        end
        MODE_HOLD: begin
          w_data_next = r_data;
        end
        default: begin
          w_data_next = r_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_data <= w_data_next;
      r_cnt  <= w_cnt_next;
      r_done <= w_done_next;
    end
  end

  assign p_out    = r_data;
  assign s_out_up = r_data[TOTAL_W-1 -: DATA_W];
  assign s_out_dn = r_data[DATA_W-1:0];
  assign cnt      = r_cnt;
  assign done     = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Randomized + directed bench for universal_shift_reg: instance 0 is 8x1, instance 1 is 4x4,
// both checked every cycle against a packed-word arithmetic model.
module tb_universal_shift_reg;

`ifdef USR_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_en, a_rot;
  logic [1:0]  a_mode;
  logic [0:0]  a_sin;
  logic [7:0]  a_pin, a_pout;
  logic [0:0]  a_up, a_dn;
  logic [3:0]  a_cnt;
  logic        a_done;

  logic        b_rst, b_en, b_rot;
  logic [1:0]  b_mode;
  logic [3:0]  b_sin;
  logic [15:0] b_pin, b_pout;
  logic [3:0]  b_up, b_dn;
  logic [2:0]  b_cnt;
  logic        b_done;

  universal_shift_reg #(.DATA_W(1), .DEPTH(8)) u_a (
    .clk(clk), .reset(a_rst), .en(a_en), .mode(a_mode), .s_in(a_sin), .rot(a_rot),
    .p_in(a_pin), .p_out(a_pout), .s_out_up(a_up), .s_out_dn(a_dn), .cnt(a_cnt), .done(a_done)
  );

  universal_shift_reg #(.DATA_W(4), .DEPTH(4)) u_b (
    .clk(clk), .reset(b_rst), .en(b_en), .mode(b_mode), .s_in(b_sin), .rot(b_rot),
    .p_in(b_pin), .p_out(b_pout), .s_out_up(b_up), .s_out_dn(b_dn), .cnt(b_cnt), .done(b_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: whole register held as one integer word; lane 0 is the low bits.
  longint mw[2];
  int     mc[2];
  bit     md[2];

  function automatic int dep(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic int dwid(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic mdl(input int k, input bit rst, input bit en, input logic [1:0] mode,
                     input longint sin, input bit rot, input longint pin);
    int d = dep(k);
    int w = dwid(k);
    longint full = (longint'(1) << (d * w)) - 1;
    longint lane = (longint'(1) << w) - 1;
    longint fill;
    if (rst) begin
      mw[k] = 0; mc[k] = 0; md[k] = 0;
      return;
    end
    md[k] = 0;
    if (!en) return;
    if (mode == 2'b11) begin
      mw[k] = pin & full;
      mc[k] = 0;
    end else if (mode == 2'b01 || mode == 2'b10) begin
      fill = sin & lane;
      if (ROT_EN && rot)
        fill = (mode == 2'b01) ? ((mw[k] >> (w * (d - 1))) & lane) : (mw[k] & lane);
      if (mode == 2'b01) mw[k] = ((mw[k] << w) | fill) & full;
      else               mw[k] = (mw[k] >> w) | (fill << (w * (d - 1)));
      if (mc[k] < d) begin
        mc[k]++;
        if (mc[k] == d) md[k] = 1;
      end
    end
  endtask

  task automatic check_all();
    check("a.p_out", 64'(a_pout), mw[0]);
    check("a.s_out_up", 64'(a_up), (mw[0] >> 7) & 1);
    check("a.s_out_dn", 64'(a_dn), mw[0] & 1);
    check("a.cnt", 64'(a_cnt), 64'(mc[0]));
    check("a.done", 64'(a_done), 64'(md[0]));
    check("b.p_out", 64'(b_pout), mw[1]);
    check("b.s_out_up", 64'(b_up), (mw[1] >> 12) & 15);
    check("b.s_out_dn", 64'(b_dn), mw[1] & 15);
    check("b.cnt", 64'(b_cnt), 64'(mc[1]));
    check("b.done", 64'(b_done), 64'(md[1]));
  endtask

  // One clock on instance k; the other instance sits with en=0.
  task automatic cyc(input int k, input bit rst, input bit en, input logic [1:0] mode,
                     input longint sin, input bit rot, input longint pin);
    a_rst = 1'b0; a_en = 1'b0; b_rst = 1'b0; b_en = 1'b0;
    if (k == 0) begin
      a_rst = rst; a_en = en; a_mode = mode; a_sin = 1'(sin); a_rot = rot; a_pin = 8'(pin);
    end else begin
      b_rst = rst; b_en = en; b_mode = mode; b_sin = 4'(sin); b_rot = rot; b_pin = 16'(pin);
    end
    @(posedge clk);
    mdl(k, rst, en, mode, sin, rot, pin);
    mdl(1 - k, 1'b0, 1'b0, 2'b00, 0, 1'b0, 0);
    #1;
    check_all();
  endtask

  logic [7:0] pat;
  int done_seen;

  initial begin
    a_mode = 2'b00; a_sin = '0; a_rot = 1'b0; a_pin = '0;
    b_mode = 2'b00; b_sin = '0; b_rot = 1'b0; b_pin = '0;
    a_rst = 1'b1; b_rst = 1'b1; a_en = 1'b1; b_en = 1'b1;
    @(posedge clk);
    mdl(0, 1'b1, 1'b0, 2'b00, 0, 1'b0, 0);
    mdl(1, 1'b1, 1'b0, 2'b00, 0, 1'b0, 0);
    #1;
    check("reset.a_pout", 64'(a_pout), 64'h0);
    check("reset.b_cnt", 64'(b_cnt), 64'h0);
    check_all();

    // Serial fill up: first bit emerges on s_out_up after 8 shifts.
    pat = 8'b0100_1101;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1'b0, 1'b1, 2'b01, longint'(pat[i]), 1'b0, 0);
      done_seen += int'(a_done);
    end
    check("fill.p_out", 64'(a_pout), 64'hB2);
    check("fill.cnt", 64'(a_cnt), 64'd8);
    check("fill.done", 64'(a_done), 64'd1);
    check("fill.s_out_up", 64'(a_up), 64'd1);
    cyc(0, 1'b0, 1'b1, 2'b01, 1, 1'b0, 0);
    check("fill.no_second_done", 64'(a_done), 64'd0);
    check("fill.done_count", 64'(done_seen), 64'd1);

    // Load then drain down.
    cyc(0, 1'b0, 1'b1, 2'b11, 0, 1'b0, 64'hA5);
    pat = 8'hA5;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      check("drain.s_out_dn", 64'(a_dn), 64'(pat[i]));
      cyc(0, 1'b0, 1'b1, 2'b10, 0, 1'b0, 0);
      done_seen += int'(a_done);
    end
    check("drain.p_out", 64'(a_pout), 64'h0);
    check("drain.done_count", 64'(done_seen), 64'd1);

    // Stall with en=0 after 3 shifts.
    cyc(0, 1'b1, 1'b1, 2'b00, 0, 1'b0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b1, 2'b01, 1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b0, 1'b0, 2'b01, 0, 1'b0, 0);
      check("stall.p_out", 64'(a_pout), 64'h07);
      check("stall.cnt", 64'(a_cnt), 64'd3);
      check("stall.done", 64'(a_done), 64'd0);
    end

    // Mid-frame reset at cnt=5.
    for (int i = 0; i < 2; i++) cyc(0, 1'b0, 1'b1, 2'b10, 1, 1'b0, 0);
    check("midrst.cnt_before", 64'(a_cnt), 64'd5);
    cyc(0, 1'b1, 1'b1, 2'b01, 1, 1'b0, 0);
    check("midrst.p_out", 64'(a_pout), 64'h0);
    check("midrst.cnt", 64'(a_cnt), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1'b0, 1'b1, 2'b01, 1, 1'b0, 0);
      done_seen += int'(a_done);
    end
    check("midrst.no_early_done", 64'(done_seen), 64'd0);
    cyc(0, 1'b0, 1'b1, 2'b10, 0, 1'b0, 0);
    check("midrst.done_at_8", 64'(a_done), 64'd1);

    // Rotate request on a single up-shift.
    cyc(0, 1'b0, 1'b1, 2'b11, 0, 1'b0, 64'h81);
    cyc(0, 1'b0, 1'b1, 2'b01, 0, 1'b1, 0);
    check("rot.first", 64'(a_pout), ROT_EN ? 64'h03 : 64'h02);
`ifdef USR_ROTATE_EN
    done_seen = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1'b0, 1'b1, 2'b01, 0, 1'b1, 0);
      done_seen += int'(a_done);
    end
    check("rot.full_circle", 64'(a_pout), 64'h81);
    check("rot.done_count", 64'(done_seen), 64'd1);
`endif

    // Wide lanes.
    cyc(1, 1'b0, 1'b1, 2'b11, 0, 1'b0, 64'h1234);
    cyc(1, 1'b0, 1'b1, 2'b01, 64'hF, 1'b0, 0);
    check("wide.up_p_out", 64'(b_pout), 64'h234F);
    check("wide.s_out_up", 64'(b_up), 64'h2);
    cyc(1, 1'b0, 1'b1, 2'b10, 0, 1'b0, 0);
    check("wide.dn_p_out", 64'(b_pout), 64'h0234);

    // Random traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      cyc(int'($urandom_range(1, 0)), ($urandom_range(99, 0) < 3), ($urandom_range(9, 0) < 8),
          2'($urandom_range(3, 0)), longint'($urandom), 1'($urandom_range(1, 0)),
          longint'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
